// File: rtl/pipe_trap_ctrl_if.sv
// Trap controller bus: ID-stage view, IRQ lines and mask/ack in,
// redirect/flush/EPC controls and status out.
interface pipe_trap_ctrl_if #(
    parameter int N_IRQ   = 4,
    parameter int CAUSE_W = 4
);
    logic [N_IRQ-1:0]   irq_in;
    logic               irq_mask_we;
    logic [N_IRQ-1:0]   irq_mask_wdata;
    logic [N_IRQ-1:0]   irq_ack;
    logic               id_valid;
    logic [5:0]         id_opcode;
    logic [5:0]         id_funct;
    logic               id_pc_31;
    logic               stall;
    logic               trap;
    logic [2:0]         trap_src;
    logic [CAUSE_W-1:0] trap_cause;
    logic               flush;
    logic               epc_we;
    logic [N_IRQ-1:0]   irq_pending;
    logic [N_IRQ-1:0]   irq_mask;
    logic               in_service;

    modport master (
        output irq_in, irq_mask_we, irq_mask_wdata, irq_ack,
        output id_valid, id_opcode, id_funct, id_pc_31, stall,
        input  trap, trap_src, trap_cause, flush, epc_we,
        input  irq_pending, irq_mask, in_service
    );

    modport slave (
        input  irq_in, irq_mask_we, irq_mask_wdata, irq_ack,
        input  id_valid, id_opcode, id_funct, id_pc_31, stall,
        output trap, trap_src, trap_cause, flush, epc_we,
        output irq_pending, irq_mask, in_service
    );
endinterface

// File: rtl/pipe_trap_ctrl.sv
// Interrupt/exception sequencer: edge-latched IRQs, illegal-op
// detection in ID, one-shot trap redirect, no nesting.
module pipe_trap_ctrl #(
    parameter int               N_IRQ    = 4,
    parameter int               CAUSE_W  = 4,
    parameter logic [N_IRQ-1:0] MASK_RST = {N_IRQ{1'b1}}
) (
    input logic             clk,
    input logic             reset,
    pipe_trap_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRAP    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [2:0] SRC_IRQ = 3'b100;
    localparam logic [2:0] SRC_EXC = 3'b101;

    state_t             state;
    state_t             stateNext;
    logic [N_IRQ-1:0]   pendingQ;
    logic [N_IRQ-1:0]   maskQ;
    logic [N_IRQ-1:0]   irqPrev;
    logic [2:0]         srcQ;
    logic [2:0]         srcD;
    logic [CAUSE_W-1:0] causeQ;
    logic [CAUSE_W-1:0] causeD;
    logic [N_IRQ-1:0]   active;
    logic [CAUSE_W-1:0] irqCause;
    logic               illegal;
    logic               arm;

    assign active = pendingQ & maskQ;
    assign arm    = bus.id_valid & ~bus.stall & ~bus.id_pc_31;

    always_comb begin
        irqCause = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (active[i]) irqCause = CAUSE_W'(i + 1);
        end
    end

    always_comb begin
        illegal = 1'b1;
        unique case (bus.id_opcode)
            6'h00: begin
                unique case (bus.id_funct)
                    6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
                    6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A:   illegal = 1'b0;
                    default: illegal = 1'b1;
                endcase
            end
            6'h01, 6'h02, 6'h03,
            6'h04, 6'h05, 6'h06, 6'h07,
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
            6'h0F, 6'h23, 6'h2B: illegal = 1'b0;
            default:             illegal = 1'b1;
        endcase
    end

    // Set wins over ack so a re-raised edge is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            pendingQ <= '0;
            maskQ    <= MASK_RST;
            irqPrev  <= '0;
        end else begin
            pendingQ <= (pendingQ & ~bus.irq_ack)
                      | (bus.irq_in & ~irqPrev);
            irqPrev  <= bus.irq_in;
            if (bus.irq_mask_we) maskQ <= bus.irq_mask_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            srcQ   <= 3'b000;
            causeQ <= '0;
        end else begin
            state  <= stateNext;
            srcQ   <= srcD;
            causeQ <= causeD;
        end
    end

    always_comb begin
        stateNext = state;
        srcD      = srcQ;
        causeD    = causeQ;
        unique case (state)
            IDLE: begin
                if (arm && illegal) begin
                    stateNext = TRAP;
                    srcD      = SRC_EXC;
                    causeD    = '0;
                end else if (arm && |active) begin
                    stateNext = TRAP;
                    srcD      = SRC_IRQ;
                    causeD    = irqCause;
                end
            end
            TRAP: begin
                if (!bus.stall) stateNext = SERVICE;
            end
            SERVICE: begin
                if (bus.id_valid && !bus.id_pc_31) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Src/cause stay visible through SERVICE for the handler.
    assign bus.trap        = (state == TRAP);
    assign bus.flush       = bus.trap;
    assign bus.epc_we      = bus.trap;
    assign bus.in_service  = (state != IDLE);
    assign bus.trap_src    = (state == IDLE) ? 3'b000 : srcQ;
    assign bus.trap_cause  = (state == IDLE) ? '0 : causeQ;
    assign bus.irq_pending = pendingQ;
    assign bus.irq_mask    = maskQ;

endmodule

// File: tb/tb_pipe_trap_ctrl.sv
// Bench for pipe_trap_ctrl: directed scenarios then random traffic,
// all checked against a behavioural model of the trap rules.
module tb_pipe_trap_ctrl;
    localparam int N  = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_trap_ctrl_if #(.N_IRQ(N), .CAUSE_W(CW)) bus ();

    pipe_trap_ctrl #(
        .N_IRQ(N), .CAUSE_W(CW), .MASK_RST(4'hF)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int passed = 0;
    int total  = 0;

    int mPend, mMask, mPrev, mSrc, mCause;
    bit mPulse, mServ;
    int cnt;

    function automatic bit isIllegal(int op, int fn);
        if (op == 0) return !(fn inside {0, 2, 3, 8, 9, [32:39], 42});
        return !(op inside {[1:12], 15, 35, 43});
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // One clock edge of the trap rules, using pre-edge inputs.
    task automatic modelEdge();
        int irq, act, newPend;
        bit arm;
        if (reset) begin
            mPend = 0; mMask = 15; mPrev = 0;
            mPulse = 0; mServ = 0; mSrc = 0; mCause = 0;
            return;
        end
        irq = int'(bus.irq_in);
        act = mPend & mMask;
        arm = bus.id_valid && !bus.stall && !bus.id_pc_31;
        newPend = (mPend & ~int'(bus.irq_ack) & 15) | (irq & ~mPrev & 15);
        if (!mPulse && !mServ) begin
            if (arm && isIllegal(int'(bus.id_opcode), int'(bus.id_funct))) begin
                mPulse = 1; mSrc = 5; mCause = 0;
            end else if (arm && act != 0) begin
                mPulse = 1; mSrc = 4;
                for (int i = N - 1; i >= 0; i--)
                    if ((act >> i) & 1) mCause = i + 1;
            end
        end else if (mPulse) begin
            if (!bus.stall) begin mPulse = 0; mServ = 1; end
        end else if (bus.id_valid && !bus.id_pc_31) begin
            mServ = 0;
        end
        mPend = newPend;
        if (bus.irq_mask_we) mMask = int'(bus.irq_mask_wdata);
        mPrev = irq;
    endtask

    task automatic checkAll(string tag);
        bit idle;
        idle = !mPulse && !mServ;
        chk({tag, ".trap"}, 32'(bus.trap), 32'(mPulse));
        chk({tag, ".flush"}, 32'(bus.flush), 32'(mPulse));
        chk({tag, ".epc_we"}, 32'(bus.epc_we), 32'(mPulse));
        chk({tag, ".src"}, 32'(bus.trap_src), idle ? 0 : mSrc);
        chk({tag, ".cause"}, 32'(bus.trap_cause), idle ? 0 : mCause);
        chk({tag, ".pending"}, 32'(bus.irq_pending), mPend);
        chk({tag, ".mask"}, 32'(bus.irq_mask), mMask);
        chk({tag, ".in_service"}, 32'(bus.in_service), 32'(!idle));
    endtask

    task automatic step(string tag);
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(tag);
    endtask

    initial begin
        reset = 1'b1;
        bus.irq_in = '0; bus.irq_mask_we = 0; bus.irq_mask_wdata = '0;
        bus.irq_ack = '0; bus.id_valid = 0; bus.id_opcode = 6'h23;
        bus.id_funct = '0; bus.id_pc_31 = 0; bus.stall = 0;
        mPend = 0; mMask = 15; mPrev = 0; mPulse = 0; mServ = 0;
        mSrc = 0; mCause = 0;
        step("rst0");
        step("rst1");
        chk("rst.mask", 32'(bus.irq_mask), 32'hF);
        chk("rst.trap", 32'(bus.trap), 0);
        reset = 1'b0;
        step("idle");

        bus.id_valid = 1; bus.irq_in = 4'b0100;
        step("t1.edge");
        chk("t1.pend", 32'(bus.irq_pending), 32'h4);
        chk("t1.notyet", 32'(bus.trap), 0);
        step("t1.dec");
        chk("t1.trap", 32'(bus.trap), 1);
        chk("t1.src", 32'(bus.trap_src), 32'h4);
        chk("t1.cause", 32'(bus.trap_cause), 3);
        bus.id_pc_31 = 1;
        step("t1.svc");
        chk("t1.pulse", 32'(bus.trap), 0);
        bus.irq_ack = 4'b0100;
        step("t1.ack");
        bus.irq_ack = '0; bus.irq_in = '0; bus.id_pc_31 = 0;
        step("t1.ret");
        step("t1.idle");

        bus.irq_in = 4'b1010;
        step("t2.edge");
        step("t2.dec");
        chk("t2.cause", 32'(bus.trap_cause), 2);
        bus.id_pc_31 = 1; bus.irq_ack = 4'b0010;
        step("t2.ack");
        bus.irq_ack = '0; bus.irq_mask_we = 1; bus.irq_mask_wdata = 4'b0101;
        step("t2.mask");
        bus.irq_mask_we = 0; bus.irq_in = '0;
        step("t2.low");
        bus.irq_in = 4'b1000;
        step("t2.re");
        bus.id_pc_31 = 0;
        repeat (3) step("t2.masked");
        chk("t2.notrap", 32'(bus.trap), 0);

        bus.irq_ack = 4'b1000; bus.id_pc_31 = 1;
        bus.irq_mask_we = 1; bus.irq_mask_wdata = 4'hF;
        step("t3.prep");
        bus.irq_ack = '0; bus.irq_mask_we = 0; bus.irq_in = 4'b1001;
        step("t3.edge");
        bus.id_pc_31 = 0; bus.id_opcode = 6'h3F;
        step("t3.dec");
        chk("t3.src", 32'(bus.trap_src), 32'h5);
        chk("t3.cause", 32'(bus.trap_cause), 0);
        bus.id_pc_31 = 1; bus.id_opcode = 6'h23; bus.irq_ack = 4'b0001;
        step("t3.svc");
        bus.irq_ack = '0; bus.id_pc_31 = 0; bus.irq_in = '0;
        step("t3.ret");

        bus.irq_in = 4'b0100;
        step("t4.edge");
        cnt = 0;
        step("t4.dec");
        cnt += int'(bus.trap);
        bus.stall = 1;
        repeat (3) begin
            step("t4.stall");
            cnt += int'(bus.trap);
        end
        bus.stall = 0;
        step("t4.go");
        cnt += int'(bus.trap);
        chk("t4.len", 32'(cnt), 4);

        bus.id_pc_31 = 1; bus.irq_ack = 4'b0100;
        bus.irq_in = 4'b0101;
        bus.irq_mask_we = 1; bus.irq_mask_wdata = 4'b1101;
        step("t5.kedge");
        bus.irq_ack = '0; bus.irq_mask_we = 0;
        step("t5.kern");
        chk("t5.nonest", 32'(bus.trap), 0);
        bus.id_pc_31 = 0;
        step("t5.ret");
        chk("t5.idle", 32'(bus.in_service), 0);
        step("t5.dec");
        chk("t5.trap", 32'(bus.trap), 1);
        chk("t5.cause", 32'(bus.trap_cause), 1);

        reset = 1;
        step("t6.rst");
        chk("t6.trap", 32'(bus.trap), 0);
        chk("t6.pend", 32'(bus.irq_pending), 0);
        chk("t6.mask", 32'(bus.irq_mask), 32'hF);
        reset = 0;

        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) bus.irq_in = 4'($urandom_range(0, 15));
            bus.irq_ack = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            bus.irq_mask_we = ($urandom_range(0, 15) == 0);
            bus.irq_mask_wdata = 4'($urandom_range(0, 15));
            bus.id_valid = ($urandom_range(0, 3) != 0);
            bus.id_pc_31 = ($urandom_range(0, 2) == 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.id_funct = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 3))
                0: bus.id_opcode = 6'h00;
                1: bus.id_opcode = 6'($urandom_range(0, 63));
                default: bus.id_opcode = 6'h23;
            endcase
            reset = ($urandom_range(0, 127) == 0);
            step("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
